// File: rtl/deblock_frame_ctrl.sv
// Frame sequencer for the 8-lane RS-decode -> MAC deblock path: per-lane completion/hold, timeout, read-out launch.
// Optional feature: define DEBLOCK_ERR_DROP_EN to drop complete frames whose error map is nonzero instead of forwarding them.
module deblock_frame_ctrl #(
  parameter int unsigned LANES   = 8,
`ifdef self_rs
  parameter int unsigned RS_CNT  = 232,
`else
  parameter int unsigned RS_CNT  = 236,
`endif
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] lane_tvalid,
  input  logic [LANES-1:0] lane_tlast,
  input  logic [LANES-1:0] lane_err,
  input  logic [LANES-1:0] lane_ok,
  output logic [LANES-1:0] lane_hold,
  output logic             out_req,
  input  logic             out_ready,
  input  logic             out_last,
  output logic             frame_done,
  output logic             frame_drop,
  output logic [LANES-1:0] frame_err_map,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_bad_cnt
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TLIM  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    TONE  = TW'(1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   RS_W  = (CNT_W+1)'(RS_CNT);
  localparam logic [CNT_W:0]   ONE_W = (CNT_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ARM, S_DRAIN, S_RELEASE, S_DROP
  } state_t;

  state_t           r_state;
  logic [LANES-1:0] r_done;
  logic [LANES-1:0] r_err_map;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_byte_cnt [LANES];

  logic [LANES-1:0] w_beat;
  logic [LANES-1:0] w_last;
  logic [LANES-1:0] w_len_bad;
  logic [LANES-1:0] w_new_err;
  logic [LANES-1:0] w_map;
  logic             w_unused_ok;

  // Decoder success pulses are informational; no state depends on them.
  assign w_unused_ok = ^lane_ok;

  assign w_beat    = lane_tvalid & ~lane_hold;
  assign w_last    = w_beat & lane_tlast;
  assign w_new_err = lane_err | w_len_bad;
  assign w_map     = r_err_map | w_new_err;

  always_comb begin
    w_len_bad = '0;
    for (int unsigned j = 0; j < LANES; j++)
      w_len_bad[j] = w_last[j] && (({1'b0, r_byte_cnt[j]} + ONE_W) != RS_W);
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_done        <= '0;
      r_err_map     <= '0;
      r_timer       <= '0;
      lane_hold     <= '0;
      out_req       <= 1'b0;
      frame_done    <= 1'b0;
      frame_drop    <= 1'b0;
      frame_err_map <= '0;
      frame_ok_cnt  <= '0;
      frame_bad_cnt <= '0;
      for (int unsigned j = 0; j < LANES; j++)
        r_byte_cnt[j] <= '0;
    end else begin
      frame_done <= 1'b0;
      for (int unsigned j = 0; j < LANES; j++) begin
        if (w_beat[j]) begin
          if (lane_tlast[j])
            r_byte_cnt[j] <= '0;
          else if (r_byte_cnt[j] != '1)
            r_byte_cnt[j] <= r_byte_cnt[j] + ONE;
        end
      end
      r_done    <= r_done | w_last;
      r_err_map <= w_map;
      lane_hold <= lane_hold | w_last;

      case (r_state)
        S_IDLE: begin
          if (r_done != '0) begin
            r_state <= S_COLLECT;
            r_timer <= '0;
          end
        end
        S_COLLECT: begin
          r_timer <= r_timer + TONE;
          if (&r_done) begin
`ifdef DEBLOCK_ERR_DROP_EN
            if (w_map != '0) begin
              r_state       <= S_DROP;
              frame_done    <= 1'b1;
              frame_drop    <= 1'b1;
              frame_err_map <= w_map;
              frame_bad_cnt <= sat_inc(frame_bad_cnt);
            end else begin
              r_state <= S_ARM;
              out_req <= 1'b1;
            end
`else
            r_state <= S_ARM;
            out_req <= 1'b1;
`endif
          end else if (r_timer == TLIM) begin
            // Lanes that never delivered tlast are reported as errors.
            r_state       <= S_DROP;
            frame_done    <= 1'b1;
            frame_drop    <= 1'b1;
            frame_err_map <= w_map | ~r_done;
            frame_bad_cnt <= sat_inc(frame_bad_cnt);
          end
        end
        S_ARM: begin
          if (out_ready) begin
            out_req <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_last) begin
            r_state       <= S_RELEASE;
            frame_done    <= 1'b1;
            frame_drop    <= 1'b0;
            frame_err_map <= w_map;
            frame_ok_cnt  <= sat_inc(frame_ok_cnt);
            if (w_map != '0)
              frame_bad_cnt <= sat_inc(frame_bad_cnt);
          end
        end
        S_RELEASE, S_DROP: begin
          // Only activity from this very cycle carries into the next frame.
          r_state   <= S_IDLE;
          r_done    <= w_last;
          r_err_map <= w_new_err;
          lane_hold <= w_last;
          r_timer   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deblock_frame_ctrl.sv
// Randomized self-checking bench for deblock_frame_ctrl against a frame-level reference model.
module tb_deblock_frame_ctrl;

  localparam int L  = 8;
  localparam int RS = 24;
  localparam int TO = 128;
  localparam int CW = 6;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [L-1:0]  lane_tvalid, lane_tlast, lane_err, lane_ok, lane_hold;
  logic          out_req, out_ready, out_last, frame_done, frame_drop;
  logic [L-1:0]  frame_err_map;
  logic [CW-1:0] frame_ok_cnt, frame_bad_cnt;

  deblock_frame_ctrl #(.LANES(L), .RS_CNT(RS), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .lane_tvalid(lane_tvalid), .lane_tlast(lane_tlast),
    .lane_err(lane_err), .lane_ok(lane_ok), .lane_hold(lane_hold),
    .out_req(out_req), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .frame_drop(frame_drop), .frame_err_map(frame_err_map),
    .frame_ok_cnt(frame_ok_cnt), .frame_bad_cnt(frame_bad_cnt)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Frame description and model state
  int          f_n [L];
  logic [L-1:0] f_last, f_errm;
  int          f_stag, f_rdy;
  bit          f_rst, f_dense;
  int          carry [L];
  int          exp_ok, exp_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    lane_tvalid = '0; lane_tlast = '0; lane_err = '0; lane_ok = '0;
    out_ready = 1'b0; out_last = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {33'd0, lane_hold, out_req, frame_done, frame_drop, frame_err_map, frame_ok_cnt, frame_bad_cnt};
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic set_clean;
    for (int j = 0; j < L; j++) begin
      f_n[j] = RS - carry[j];
      if (f_n[j] < 1) f_n[j] = 1;
    end
    f_last = '1; f_errm = '0; f_stag = 0; f_rdy = 0; f_rst = 1'b0; f_dense = 1'b0;
  endtask

  task automatic run_frame;
    int rem [L]; int start [L]; int err_at [L];
    int t = 0, t_first = -1, t_lastl = -1, n_lasts = 0, want_lasts;
    int rdy_wait = 0, last_wait = 0;
    logic [L-1:0] miss, lenbad, map, tv, tl;
    bit drop, req_prev = 0, req_seen = 0, hs_done = 0, hs_now, last_sent = 0, ol, finished = 0;

    miss = ~f_last;
    lenbad = '0;
    for (int j = 0; j < L; j++)
      if (f_last[j] && (carry[j] + f_n[j] != RS)) lenbad[j] = 1'b1;
    map  = miss | lenbad | f_errm;
    drop = (miss != '0);
`ifdef DEBLOCK_ERR_DROP_EN
    drop = drop || (map != '0);
`endif
    want_lasts = $countones(f_last);
    for (int j = 0; j < L; j++) begin
      rem[j]    = f_n[j];
      start[j]  = j * f_stag;
      err_at[j] = start[j] + ((f_n[j] > 0) ? $urandom_range(0, f_n[j] - 1) : 0);
    end

    while (!finished && t < 1500) begin
      if (f_rst && hs_done) begin
        drive_idle();
        reset = 1'b1;
        tick();
        check("reset_mid_drain", all_outs(), 64'd0);
        reset = 1'b0;
        exp_ok = 0; exp_bad = 0;
        for (int j = 0; j < L; j++) carry[j] = 0;
        finished = 1;
      end else begin
        for (int j = 0; j < L; j++) begin
          tv[j] = 1'b0; tl[j] = 1'b0;
          if (t >= start[j] && rem[j] > 0 && (f_dense || $urandom_range(0, 3) != 0)) begin
            tv[j] = 1'b1;
            tl[j] = (rem[j] == 1) && f_last[j];
          end
          lane_err[j] = f_errm[j] && (t == err_at[j]);
          lane_ok[j]  = ($urandom_range(0, 7) == 0);
        end
        lane_tvalid = tv; lane_tlast = tl;
        if (req_prev && !hs_done) begin
          if (rdy_wait > 0) begin out_ready = 1'b0; rdy_wait--; end
          else out_ready = 1'b1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        ol = 1'b0;
        if (hs_done && !last_sent) begin
          if (last_wait > 0) begin out_last = 1'b0; last_wait--; end
          else begin out_last = 1'b1; ol = 1'b1; end
        end else begin
          out_last = !req_seen && ($urandom_range(0, 15) == 0);
        end

        tick();
        t++;

        hs_now = req_prev && out_ready;
        if (ol) last_sent = 1'b1;
        for (int j = 0; j < L; j++) begin
          if (tv[j]) rem[j]--;
          if (tl[j]) begin
            check("hold_rise", lane_hold[j], 1'b1);
            n_lasts++;
            t_lastl = t;
            if (t_first < 0) t_first = t;
          end
        end
        if (hs_now) begin
          hs_done = 1'b1;
          check("req_fall", out_req, 1'b0);
          last_wait = $urandom_range(0, 4);
        end else if (req_prev && !hs_done) begin
          check("req_held", out_req, 1'b1);
        end
        if (out_req && !req_seen) begin
          req_seen = 1'b1;
          rdy_wait = f_rdy;
          check("req_latency", (n_lasts == want_lasts) && (t - t_lastl >= 1) && (t - t_lastl <= 2), 1'b1);
        end
        if (out_req && drop) check("req_on_drop", out_req, 1'b0);

        if (frame_done) begin
          check("frame_drop", frame_drop, drop);
          check("err_map", frame_err_map, map);
          if (drop) exp_bad = sat(exp_bad + 1);
          else begin
            exp_ok = sat(exp_ok + 1);
            if (map != '0) exp_bad = sat(exp_bad + 1);
          end
          check("ok_cnt", frame_ok_cnt, exp_ok);
          check("bad_cnt", frame_bad_cnt, exp_bad);
          if (drop) check("no_req_on_drop", req_seen, 1'b0);
          else check("done_after_last", last_sent, 1'b1);
          if (miss != '0)
            check("timeout_window", (t - t_first >= TO) && (t - t_first <= TO + 2), 1'b1);
          for (int j = 0; j < L; j++)
            carry[j] = f_last[j] ? 0 : carry[j] + (f_n[j] - rem[j]);
          drive_idle();
          tick();
          check("hold_clear", lane_hold, '0);
          check("done_pulse", frame_done, 1'b0);
          finished = 1;
        end
        req_prev = out_req;
      end
    end
    if (!finished) check("frame_budget", 1'b0, 1'b1);
    drive_idle();
  endtask

  initial begin
    int m;
    reset = 1'b1;
    drive_idle();
    for (int j = 0; j < L; j++) carry[j] = 0;
    exp_ok = 0; exp_bad = 0;
    tick(); tick();
    check("reset_state", all_outs(), 64'd0);
    reset = 1'b0;
    tick();

    set_clean(); f_dense = 1'b1;        run_frame();  // all lanes together
    set_clean(); f_stag = 10;           run_frame();  // staggered lanes
    set_clean(); f_n[3] = RS - 1;       run_frame();  // short lane 3
    set_clean(); f_last[5] = 1'b0; f_n[5] = 0; run_frame();  // lane 5 never finishes
    set_clean(); f_rdy = 50;            run_frame();  // read-out stalls in ARM
    set_clean(); f_rst = 1'b1;          run_frame();  // reset during DRAIN
    tick();

    for (int k = 0; k < 75; k++) begin
      set_clean();
      f_stag  = $urandom_range(0, 3);
      f_rdy   = $urandom_range(0, 4);
      f_dense = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < L; j++) begin
        if ($urandom_range(0, 5) == 0) f_n[j] = f_n[j] + $urandom_range(0, 4) - 2;
        if (f_n[j] < 1) f_n[j] = 1;
        if ($urandom_range(0, 15) == 0) f_errm[j] = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        m = $urandom_range(0, L - 1);
        f_last[m] = 1'b0;
        f_n[m] = (carry[m] <= 40) ? $urandom_range(0, ((40 - carry[m]) < RS) ? (40 - carry[m]) : RS) : 0;
      end
      run_frame();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
